// File: rtl/sgd_train_sequencer.sv
// Training-loop controller for the SGD engine: walks epochs, data points and features,
// issuing forward-MAC, error, gradient and (mini-batch) weight-update strobes.
module sgd_train_sequencer #(
  parameter int FEAT_W  = 4,
  parameter int PT_W    = 12,
  parameter int EP_W    = 8,
  parameter int BATCH_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               en,
  input  logic               start,
  input  logic               abort,
  input  logic [FEAT_W-1:0]  feat,
  input  logic [PT_W-1:0]    data_points,
  input  logic [EP_W-1:0]    epoch,
  input  logic [BATCH_W-1:0] batch,
  output logic [PT_W-1:0]    sample_addr,
  output logic [FEAT_W-1:0]  feat_idx,
  output logic               mac_vld,
  output logic               err_vld,
  output logic               grad_vld,
  output logic               upd_vld,
  output logic [EP_W-1:0]    epoch_cnt,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic               aborted
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_FWD  = 3'd2;
  localparam logic [2:0] S_ERR  = 3'd3;
  localparam logic [2:0] S_GRAD = 3'd4;
  localparam logic [2:0] S_UPD  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;
  localparam int CW = (PT_W > BATCH_W) ? PT_W : BATCH_W;

  logic [2:0]        state_q, state_d;
  logic [PT_W-1:0]   pt_q, pt_d, bc_q, bc_d, dp_q, dp_d, eff_q, eff_d;
  logic [FEAT_W-1:0] fi_q, fi_d, feat_q, feat_d;
  logic [EP_W-1:0]   ep_q, ep_d, epl_q, epl_d;
  logic              mac_q, mac_d, err_q, err_d, grad_q, grad_d, upd_q, upd_d;
  logic              busy_q, busy_d, done_q, done_d, cfg_q, cfg_d;
  logic              abrt_q, abrt_d, abreq_q, abreq_d;

  logic              arm_s, exec_s, abort_s, last_f_s, last_p_s;
  logic [PT_W-1:0]   bc_inc_s, eff_in_s;
  logic [EP_W-1:0]   ep_inc_s;
  logic [CW-1:0]     b_ext_s, dp_ext_s;

  // A strobe register being high means the displayed step is executed this cycle;
  // the step only advances once it has been executed, so en low never skips or repeats work.
  always_comb begin
    state_d = state_q;  pt_d = pt_q;  bc_d = bc_q;  fi_d = fi_q;  ep_d = ep_q;
    dp_d = dp_q;  eff_d = eff_q;  feat_d = feat_q;  epl_d = epl_q;
    done_d = done_q;  cfg_d = cfg_q;  abrt_d = abrt_q;  abreq_d = abreq_q;
    arm_s    = 1'b0;
    exec_s   = mac_q | err_q | grad_q | upd_q;
    abort_s  = abreq_q | abort;
    last_f_s = (fi_q == feat_q - FEAT_W'(1));
    last_p_s = (pt_q == dp_q - PT_W'(1));
    bc_inc_s = bc_q + PT_W'(1);
    ep_inc_s = ep_q + EP_W'(1);
    b_ext_s  = CW'(batch);
    dp_ext_s = CW'(data_points);
    eff_in_s = ((batch == {BATCH_W{1'b0}}) || (b_ext_s > dp_ext_s)) ? data_points : PT_W'(batch);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;  done_d = 1'b0;  cfg_d = 1'b0;  abrt_d = 1'b0;
          abreq_d = 1'b0;  ep_d = {EP_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        feat_d = feat;  dp_d = data_points;  epl_d = epoch;  eff_d = eff_in_s;
        if ((feat == {FEAT_W{1'b0}}) || (data_points == {PT_W{1'b0}}) || (epoch == {EP_W{1'b0}})) begin
          state_d = S_DONE;  cfg_d = 1'b1;  done_d = 1'b1;  abreq_d = 1'b0;
        end else begin
          state_d = S_FWD;  pt_d = {PT_W{1'b0}};  fi_d = {FEAT_W{1'b0}};
          ep_d = {EP_W{1'b0}};  bc_d = {PT_W{1'b0}};  arm_s = en;  abreq_d = abort;
        end
      end
      S_FWD, S_ERR, S_GRAD, S_UPD: begin
        abreq_d = abort_s;
        arm_s   = en;
        if (!exec_s) begin
          state_d = state_q;
        end else begin
          case (state_q)
            S_FWD: begin
              if (last_f_s) begin
                state_d = S_ERR;  fi_d = {FEAT_W{1'b0}};
              end else begin
                fi_d = fi_q + FEAT_W'(1);
              end
            end
            S_ERR: begin
              state_d = S_GRAD;  fi_d = {FEAT_W{1'b0}};
            end
            S_GRAD: begin
              if (!last_f_s) begin
                fi_d = fi_q + FEAT_W'(1);
              end else if (abort_s || (bc_inc_s == eff_q) || last_p_s) begin
                fi_d = {FEAT_W{1'b0}};  bc_d = bc_inc_s;  state_d = S_UPD;
              end else begin
                fi_d = {FEAT_W{1'b0}};  bc_d = bc_inc_s;  pt_d = pt_q + PT_W'(1);  state_d = S_FWD;
              end
            end
            S_UPD: begin
              if (!last_f_s) begin
                fi_d = fi_q + FEAT_W'(1);
              end else begin
                fi_d = {FEAT_W{1'b0}};  bc_d = {PT_W{1'b0}};
                if (last_p_s) begin
                  pt_d = {PT_W{1'b0}};  ep_d = ep_inc_s;
                end else begin
                  pt_d = pt_q + PT_W'(1);
                end
                if (abort_s || (last_p_s && (ep_inc_s == epl_q))) begin
                  state_d = S_DONE;  done_d = 1'b1;  abrt_d = abort_s;  abreq_d = 1'b0;
                end else begin
                  state_d = S_FWD;
                end
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
    mac_d  = arm_s && (state_d == S_FWD);
    err_d  = arm_s && (state_d == S_ERR);
    grad_d = arm_s && (state_d == S_GRAD);
    upd_d  = arm_s && (state_d == S_UPD);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;  pt_q <= {PT_W{1'b0}};  bc_q <= {PT_W{1'b0}};
      dp_q <= {PT_W{1'b0}};  eff_q <= {PT_W{1'b0}};  fi_q <= {FEAT_W{1'b0}};
      feat_q <= {FEAT_W{1'b0}};  ep_q <= {EP_W{1'b0}};  epl_q <= {EP_W{1'b0}};
      mac_q <= 1'b0;  err_q <= 1'b0;  grad_q <= 1'b0;  upd_q <= 1'b0;
      busy_q <= 1'b0;  done_q <= 1'b0;  cfg_q <= 1'b0;  abrt_q <= 1'b0;  abreq_q <= 1'b0;
    end else begin
      state_q <= state_d;  pt_q <= pt_d;  bc_q <= bc_d;  dp_q <= dp_d;  eff_q <= eff_d;
      fi_q <= fi_d;  feat_q <= feat_d;  ep_q <= ep_d;  epl_q <= epl_d;
      mac_q <= mac_d;  err_q <= err_d;  grad_q <= grad_d;  upd_q <= upd_d;
      busy_q <= busy_d;  done_q <= done_d;  cfg_q <= cfg_d;  abrt_q <= abrt_d;  abreq_q <= abreq_d;
    end
  end

  assign sample_addr = pt_q;
  assign feat_idx    = fi_q;
  assign epoch_cnt   = ep_q;
  assign mac_vld     = mac_q;
  assign err_vld     = err_q;
  assign grad_vld    = grad_q;
  assign upd_vld     = upd_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_q;
  assign aborted     = abrt_q;

endmodule

// File: tb/tb_sgd_train_sequencer.sv
// Bench for sgd_train_sequencer: a step-list reference model checked every cycle,
// directed runs with hand-computed edge/strobe counts, then randomized runs.
module tb_sgd_train_sequencer;
  localparam int FEAT_W = 4, PT_W = 12, EP_W = 8, BATCH_W = 8;

  logic CLK = 1'b0, RST = 1'b0, en = 1'b0, start = 1'b0, abort = 1'b0;
  logic [FEAT_W-1:0]  feat = '0;
  logic [PT_W-1:0]    data_points = '0;
  logic [EP_W-1:0]    epoch = '0;
  logic [BATCH_W-1:0] batch = '0;
  logic [PT_W-1:0]    sample_addr;
  logic [FEAT_W-1:0]  feat_idx;
  logic [EP_W-1:0]    epoch_cnt;
  logic mac_vld, err_vld, grad_vld, upd_vld, busy, done, cfg_err, aborted;

  sgd_train_sequencer #(.FEAT_W(FEAT_W), .PT_W(PT_W), .EP_W(EP_W), .BATCH_W(BATCH_W)) dut (
    .CLK(CLK), .RST(RST), .en(en), .start(start), .abort(abort), .feat(feat),
    .data_points(data_points), .epoch(epoch), .batch(batch), .sample_addr(sample_addr),
    .feat_idx(feat_idx), .mac_vld(mac_vld), .err_vld(err_vld), .grad_vld(grad_vld),
    .upd_vld(upd_vld), .epoch_cnt(epoch_cnt), .busy(busy), .done(done),
    .cfg_err(cfg_err), .aborted(aborted));

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: the whole run is an ordered list of work steps
  // (kind 0=fwd 1=err 2=grad 3=upd); stalls only delay walking through it.
  typedef struct { int kind; int pt; int fi; int ep; } step_t;
  step_t sq[$];
  int m_ph = 0;              // 0 idle, 1 load, 2 running, 3 done
  int m_idx = 0, m_fep = 0, m_feat = 0, m_dp = 0, m_ep = 0;
  bit m_exec = 0, m_cfg = 0, m_abrt = 0, m_pend = 0;

  function automatic void push(int k, int p, int f, int e);
    step_t s;
    s.kind = k; s.pt = p; s.fi = f; s.ep = e;
    sq.push_back(s);
  endfunction

  function automatic void build(int b);
    int eff, bc;
    eff = (b == 0 || b > m_dp) ? m_dp : b;
    sq.delete();
    for (int e = 0; e < m_ep; e++) begin
      bc = 0;
      for (int p = 0; p < m_dp; p++) begin
        for (int f = 0; f < m_feat; f++) push(0, p, f, e);
        push(1, p, 0, e);
        for (int f = 0; f < m_feat; f++) push(2, p, f, e);
        bc++;
        if (bc == eff || p == m_dp - 1) begin
          for (int f = 0; f < m_feat; f++) push(3, p, f, e);
          bc = 0;
        end
      end
    end
  endfunction

  function automatic void truncate(int i);
    step_t s;
    int j;
    s = sq[i];
    j = i;
    if (s.kind == 3) begin
      while (j + 1 < sq.size() && sq[j+1].kind == 3) j++;
    end else begin
      while (!(sq[j].kind == 2 && sq[j].fi == m_feat - 1)) j++;
    end
    while (sq.size() > j + 1) sq.delete(sq.size() - 1);
    if (s.kind != 3) for (int f = 0; f < m_feat; f++) push(3, s.pt, f, s.ep);
    m_fep = s.ep + ((s.pt == m_dp - 1) ? 1 : 0);
  endfunction

  // Advance the model on every edge, then compare all outputs shortly after.
  always @(posedge CLK) begin
    step_t s;
    if (!RST) begin
      m_ph = 0; m_cfg = 0; m_abrt = 0; m_pend = 0; m_fep = 0; m_exec = 0;
    end else begin
      case (m_ph)
        0, 3: if (start) begin m_ph = 1; m_cfg = 0; m_abrt = 0; m_pend = 0; m_fep = 0; end
        1: begin
          m_feat = int'(feat); m_dp = int'(data_points); m_ep = int'(epoch);
          if (m_feat == 0 || m_dp == 0 || m_ep == 0) begin
            m_ph = 3; m_cfg = 1; m_fep = 0;
          end else begin
            build(int'(batch));
            m_fep = m_ep; m_idx = 0; m_exec = en; m_ph = 2;
            if (abort) begin truncate(0); m_pend = 1; end
          end
        end
        default: begin
          if (abort && !m_pend) begin truncate(m_idx); m_pend = 1; end
          if (m_exec) begin
            m_idx++;
            if (m_idx >= sq.size()) begin m_ph = 3; m_abrt = m_pend; m_pend = 0; end
            else m_exec = en;
          end else m_exec = en;
        end
      endcase
    end
    #1;
    chk("busy", busy, (m_ph == 1 || m_ph == 2));
    chk("done", done, (m_ph == 3));
    chk("cfg_err", cfg_err, m_cfg);
    chk("aborted", aborted, m_abrt);
    if (m_ph == 2) begin
      s = sq[m_idx];
      chk("strobes", {mac_vld, err_vld, grad_vld, upd_vld},
          m_exec ? (4'b1000 >> s.kind) : 4'b0000);
      chk("sample_addr", sample_addr, s.pt);
      chk("feat_idx", feat_idx, s.fi);
      chk("epoch_cnt", epoch_cnt, s.ep);
    end else begin
      chk("strobes", {mac_vld, err_vld, grad_vld, upd_vld}, 0);
      chk("epoch_cnt", epoch_cnt, (m_ph == 3) ? m_fep : 0);
      if (m_ph == 0) begin
        chk("sample_addr", sample_addr, 0);
        chk("feat_idx", feat_idx, 0);
      end
    end
  end

  // mode: 0 plain, 1 en-low stall in mid-GRAD, 2 abort during FWD of point 2, 3 random
  task automatic run(input int f, input int d, input int e, input int b, input int mode,
                     output int n, output int cm, output int ce, output int cg, output int cu);
    int stall_left;
    bit fired;
    feat = FEAT_W'(f); data_points = PT_W'(d); epoch = EP_W'(e); batch = BATCH_W'(b);
    en = 1'b1; start = 1'b1;
    n = 0; cm = 0; ce = 0; cg = 0; cu = 0; stall_left = 0; fired = 0;
    @(posedge CLK); #2;
    start = 1'b0;
    chk("start_clears_flags", {done, cfg_err, aborted}, 0);
    while (n < 4000) begin
      @(posedge CLK); #2;
      n++;
      cm += int'(mac_vld); ce += int'(err_vld); cg += int'(grad_vld); cu += int'(upd_vld);
      if (done) break;
      abort = 1'b0; start = 1'b0;
      if (mode == 1) begin
        if (stall_left > 0) begin
          stall_left--;
          if (stall_left == 0) en = 1'b1;
        end else if (!fired && grad_vld && feat_idx == 2) begin
          en = 1'b0; stall_left = 7; fired = 1;
        end
      end else if (mode == 2) begin
        if (!fired && mac_vld && sample_addr == 2) begin abort = 1'b1; fired = 1; end
      end else if (mode == 3) begin
        en    = ($urandom_range(9) != 0);
        abort = ($urandom_range(79) == 0);
        start = ($urandom_range(49) == 0);
      end
    end
    chk("done_within_bound", done, 1);
    abort = 1'b0; start = 1'b0; en = 1'b1;
  endtask

  initial begin
    int n, cm, ce, cg, cu;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1; en = 1'b1;

    run(4, 4, 5, 1, 0, n, cm, ce, cg, cu);
    chk("b1_edges", n, 261); chk("b1_err", ce, 20); chk("b1_upd", cu, 80);
    chk("b1_epoch_cnt", epoch_cnt, 5);

    run(4, 4, 5, 2, 0, n, cm, ce, cg, cu);
    chk("b2_edges", n, 221); chk("b2_upd", cu, 40); chk("b2_mac", cm, 80);

    run(2, 3, 1, 2, 0, n, cm, ce, cg, cu);
    chk("partial_edges", n, 20); chk("partial_upd", cu, 4); chk("partial_err", ce, 3);

    run(4, 4, 5, 1, 1, n, cm, ce, cg, cu);
    chk("stall_edges", n, 268); chk("stall_upd", cu, 80); chk("stall_grad", cg, 80);

    // done is seen one edge after LOAD, i.e. two edges counting the start edge
    run(4, 4, 0, 1, 0, n, cm, ce, cg, cu);
    chk("cfg_ep0_edges", n, 1); chk("cfg_ep0_err", cfg_err, 1);
    chk("cfg_ep0_strobes", cm + ce + cg + cu, 0);
    run(0, 4, 5, 1, 0, n, cm, ce, cg, cu);
    chk("cfg_f0_err", cfg_err, 1); chk("cfg_f0_strobes", cm + ce + cg + cu, 0);

    run(4, 4, 5, 4, 2, n, cm, ce, cg, cu);
    chk("abort_edges", n, 32); chk("abort_upd", cu, 4); chk("abort_err", ce, 3);
    chk("abort_flag", aborted, 1); chk("abort_epoch_cnt", epoch_cnt, 0);

    // reset in the middle of a run
    feat = 4'd3; data_points = 12'd5; epoch = 8'd2; batch = 8'd2; start = 1'b1;
    @(posedge CLK); #2 start = 1'b0;
    repeat (30) @(posedge CLK);
    #2 RST = 1'b0;
    @(posedge CLK); #2;
    chk("rst_busy", busy, 0);
    chk("rst_outputs", {sample_addr, feat_idx, epoch_cnt, mac_vld, err_vld, grad_vld, upd_vld}, 0);
    RST = 1'b1;

    for (int r = 0; r < 12; r++) begin
      run($urandom_range(3, 1), $urandom_range(5, 1), $urandom_range(3, 1),
          $urandom_range(6, 0), 3, n, cm, ce, cg, cu);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
